// File: rtl/cpu_rr_scheduler.sv
// cpu_rr_scheduler
//   Shares one CPU datapath among NREQ requesters. A requester is granted in
//   IDLE through a one-cycle req_ready strobe. Its command and operands are
//   held on the cpu_* outputs while the CPU works. The CPU results are
//   captured after LATENCY cycles and returned with the requester's ID.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready per-requester handshake (req_ready one-hot)
//   req_cmd/req_d1..3   packed per-requester command (7b) and operands
//   cpu_cmdin/din_1..3  command and operands driven to the CPU
//   cpu_dout_*/zero/err results coming back from the CPU
//   resp_*              one-cycle result strobe plus held ID/data/flags
//   busy                a transaction is in flight
//
// Build option
//   CPU_SCHED_FIXED_PRIO_EN : when defined, the lowest-index valid requester
//   always wins and the round-robin pointer is removed.

module cpu_rr_scheduler #(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int LATENCY = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*7-1:0]         req_cmd,
  input  logic [NREQ*WIDTH-1:0]     req_d1,
  input  logic [NREQ*WIDTH-1:0]     req_d2,
  input  logic [NREQ*WIDTH-1:0]     req_d3,
  output logic [6:0]                cpu_cmdin,
  output logic [WIDTH-1:0]          cpu_din_1,
  output logic [WIDTH-1:0]          cpu_din_2,
  output logic [WIDTH-1:0]          cpu_din_3,
  input  logic [WIDTH-1:0]          cpu_dout_low,
  input  logic [WIDTH-1:0]          cpu_dout_high,
  input  logic                      cpu_zero,
  input  logic                      cpu_error,
  output logic                      resp_valid,
  output logic [$clog2(NREQ)-1:0]   resp_id,
  output logic [2*WIDTH-1:0]        resp_data,
  output logic                      resp_zero,
  output logic                      resp_error,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     gnt_q, gnt_d;
  logic [6:0]         cmd_q, cmd_d;
  logic [WIDTH-1:0]   d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDW-1:0]     resp_id_q, resp_id_d;
  logic [2*WIDTH-1:0] resp_data_q, resp_data_d;
  logic               resp_zero_q, resp_zero_d;
  logic               resp_error_q, resp_error_d;

  logic               found;
  logic [IDW-1:0]     win_idx;

`ifdef CPU_SCHED_FIXED_PRIO_EN
  // Downward scan so the lowest set index is the last one written.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        found   = 1'b1;
        win_idx = IDW'(k);
      end
    end
  end
`else
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  off;
  logic [IDW:0]    sum;

  // Rotate the request vector so the pointer position lands at bit 0, find the
  // lowest set bit, then rotate the offset back into an absolute index.
  always_comb begin
    rot   = NREQ'({req_valid, req_valid} >> ptr_q);
    found = 1'b0;
    off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = IDW'(k);
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= (IDW + 1)'(NREQ)) begin
      sum = sum - (IDW + 1)'(NREQ);
    end
    win_idx = sum[IDW-1:0];
  end

  // The requester just served drops to lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == RESP) begin
      ptr_d = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      cmd_q        <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      d3_q         <= '0;
      cnt_q        <= '0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_zero_q  <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      cmd_q        <= cmd_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      d3_q         <= d3_d;
      cnt_q        <= cnt_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_zero_q  <= resp_zero_d;
      resp_error_q <= resp_error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    cmd_d        = cmd_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    d3_d         = d3_q;
    cnt_d        = cnt_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_zero_d  = resp_zero_q;
    resp_error_d = resp_error_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = ISSUE;
          gnt_d   = win_idx;
          cmd_d   = req_cmd[7*int'(win_idx) +: 7];
          d1_d    = req_d1[WIDTH*int'(win_idx) +: WIDTH];
          d2_d    = req_d2[WIDTH*int'(win_idx) +: WIDTH];
          d3_d    = req_d3[WIDTH*int'(win_idx) +: WIDTH];
        end
      end
      ISSUE: begin
        cnt_d   = 4'(LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          resp_id_d    = gnt_q;
          resp_data_d  = {cpu_dout_high, cpu_dout_low};
          resp_zero_d  = cpu_zero;
          resp_error_d = cpu_error;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // req_ready is gated by rst so no strobe is seen while reset holds the FSM
  // in IDLE with requests pending.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && rst && found) begin
      req_ready[win_idx] = 1'b1;
    end
    cpu_cmdin  = (state_q == ISSUE || state_q == WAIT) ? cmd_q : 7'd0;
    resp_valid = (state_q == RESP);
    busy       = (state_q != IDLE);
  end

  assign cpu_din_1  = d1_q;
  assign cpu_din_2  = d2_q;
  assign cpu_din_3  = d3_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_zero  = resp_zero_q;
  assign resp_error = resp_error_q;

endmodule

// File: tb/tb_cpu_rr_scheduler.sv
// Testbench for cpu_rr_scheduler. It contains a CPU stand-in that drives valid
// results only in the cycle the scheduler must capture them, and random junk
// at all other times. It also contains a cycle-indexed reference model that
// predicts every output from the grant time and the arbitration rule.
module tb_cpu_rr_scheduler;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int L  = 4;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*7-1:0] req_cmd = '0;
  logic [N*W-1:0] req_d1 = '0;
  logic [N*W-1:0] req_d2 = '0;
  logic [N*W-1:0] req_d3 = '0;
  logic [6:0]     cpu_cmdin;
  logic [W-1:0]   cpu_din_1, cpu_din_2, cpu_din_3;
  logic [W-1:0]   cpu_dout_low = '0;
  logic [W-1:0]   cpu_dout_high = '0;
  logic           cpu_zero = 1'b0;
  logic           cpu_error = 1'b0;
  logic           resp_valid;
  logic [IW-1:0]  resp_id;
  logic [2*W-1:0] resp_data;
  logic           resp_zero, resp_error, busy;

  int checks = 0;
  int passed = 0;

  // Reference model: t is the cycle index; a transaction is described by its
  // grant cycle gt, and every output is a function of t - gt.
  int           t = 0;
  bit           active = 1'b0;
  int           gt = 0;
  int           gidx = 0;
  int           ptr_m = 0;
  int           model_grants = 0;
  logic [6:0]   g_cmd = '0;
  logic [W-1:0] g_d1 = '0, g_d2 = '0, g_d3 = '0;
  logic [W-1:0] last_d1 = '0, last_d2 = '0, last_d3 = '0;
  bit           g_err = 1'b0;
  bit           inject_err = 1'b0;
  logic [2*W-1:0] exp_data = '0;
  bit           exp_zero = 1'b0;
  bit           exp_err = 1'b0;
  int           exp_id = 0;
  int           dut_grant_idx[$];
  int           dut_grant_t[$];
  int           dut_resp_t[$];

  always #5 clk = ~clk;

  cpu_rr_scheduler #(.WIDTH(W), .NREQ(N), .LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_d1(req_d1), .req_d2(req_d2), .req_d3(req_d3),
    .cpu_cmdin(cpu_cmdin), .cpu_din_1(cpu_din_1), .cpu_din_2(cpu_din_2),
    .cpu_din_3(cpu_din_3), .cpu_dout_low(cpu_dout_low),
    .cpu_dout_high(cpu_dout_high), .cpu_zero(cpu_zero), .cpu_error(cpu_error),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_zero(resp_zero), .resp_error(resp_error), .busy(busy)
  );

  // CPU stand-in arithmetic: odd commands add all three operands, even ones
  // multiply the first two.
  function automatic logic [2*W-1:0] cpuResult(input logic [6:0] c,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic [W-1:0] d);
    if (c[0]) return (2*W)'(a) + (2*W)'(b) + (2*W)'(d);
    return (2*W)'(a) * (2*W)'(b);
  endfunction

  function automatic int pickWinner(input logic [N-1:0] v);
`ifdef CPU_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 0; k < N; k++) if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
`endif
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
  endtask

  // Drive requester inputs for this cycle. The CPU stand-in puts the real
  // result on its outputs only in the capture cycle.
  task automatic applyStimulus(input logic [N-1:0] mask, input bit rnd);
    logic [2*W-1:0] r;
    req_valid = mask;
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        req_cmd[7*i +: 7] = 7'($urandom);
        req_d1[W*i +: W]  = W'($urandom);
        req_d2[W*i +: W]  = W'($urandom);
        req_d3[W*i +: W]  = W'($urandom);
      end
    end
    if (rst && active && t == gt + L + 1) begin
      r = cpuResult(g_cmd, g_d1, g_d2, g_d3);
      {cpu_dout_high, cpu_dout_low} = r;
      cpu_zero  = (r == '0);
      cpu_error = g_err;
    end else begin
      {cpu_dout_high, cpu_dout_low} = (2*W)'($urandom);
      cpu_zero  = 1'($urandom);
      cpu_error = 1'($urandom);
    end
  endtask

  // Compare every output against the model for cycle t, then advance the model.
  task automatic checkOutput();
    logic [N-1:0] exp_ready;
    int  w;
    bit  in_resp, in_hold;
    exp_ready = '0;
    w = -1;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] === 1'b1) begin
        dut_grant_idx.push_back(i);
        dut_grant_t.push_back(t);
      end
    end
    if (resp_valid === 1'b1) dut_resp_t.push_back(t);
    if (!rst) begin
      active = 1'b0; ptr_m = 0;
      last_d1 = '0; last_d2 = '0; last_d3 = '0;
      exp_data = '0; exp_zero = 1'b0; exp_err = 1'b0; exp_id = 0;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cpu_cmdin", 32'(cpu_cmdin), 0);
      chk("rst_cpu_din_1", 32'(cpu_din_1), 0);
      chk("rst_resp_data", 32'(resp_data), 0);
      chk("rst_resp_flags", 32'({resp_id, resp_zero, resp_error}), 0);
      t++;
      return;
    end
    if (!active) begin
      w = pickWinner(req_valid);
      if (w >= 0) exp_ready[w] = 1'b1;
    end
    in_resp = active && (t == gt + L + 2);
    in_hold = active && (t >= gt + 1) && (t <= gt + L + 1);
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("resp_valid", 32'(resp_valid), 32'(in_resp));
    chk("busy", 32'(busy), 32'(active && t > gt));
    chk("cpu_cmdin", 32'(cpu_cmdin), in_hold ? 32'(g_cmd) : 32'd0);
    chk("cpu_din_1", 32'(cpu_din_1), 32'(last_d1));
    chk("cpu_din_2", 32'(cpu_din_2), 32'(last_d2));
    chk("cpu_din_3", 32'(cpu_din_3), 32'(last_d3));
    chk("resp_id", 32'(resp_id), exp_id);
    chk("resp_data", 32'(resp_data), 32'(exp_data));
    chk("resp_zero", 32'(resp_zero), 32'(exp_zero));
    chk("resp_error", 32'(resp_error), 32'(exp_err));
    if (active && t == gt + L + 1) begin
      exp_data = cpuResult(g_cmd, g_d1, g_d2, g_d3);
      exp_zero = (exp_data == '0);
      exp_err  = g_err;
      exp_id   = gidx;
    end
    if (in_resp) begin
      active = 1'b0;
      ptr_m  = (gidx + 1) % N;
    end
    if (w >= 0) begin
      active  = 1'b1;
      gt      = t;
      gidx    = w;
      g_cmd   = req_cmd[7*w +: 7];
      g_d1    = req_d1[W*w +: W];
      g_d2    = req_d2[W*w +: W];
      g_d3    = req_d3[W*w +: W];
      last_d1 = g_d1; last_d2 = g_d2; last_d3 = g_d3;
      g_err   = inject_err;
      inject_err = 1'b0;
      model_grants++;
    end
    t++;
  endtask

  task automatic tick(input logic [N-1:0] mask, input bit rnd);
    applyStimulus(mask, rnd);
    #1;
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic waitGrant(input logic [N-1:0] mask, input bit rnd, input int budget);
    int start;
    int n;
    start = model_grants;
    n = 0;
    while (model_grants == start && n < budget) begin
      tick(mask, rnd);
      n++;
    end
    chk("grant_seen", 32'(model_grants != start), 1);
  endtask

  initial begin
    int g0;
    int n;
    int exp_idx;

    // Reset held, then released with no requests.
    rst = 1'b0;
    tick('0, 1);
    tick('0, 1);
    rst = 1'b1;
    repeat (8) tick('0, 1);

    // All requesters valid from a fresh pointer.
    g0 = dut_grant_idx.size();
    n = 0;
    while (dut_grant_idx.size() < g0 + 6 && n < 80) begin
      tick('1, 1);
      n++;
    end
    chk("allvalid_grant_count", 32'(dut_grant_idx.size() - g0), 6);
    for (int k = 0; k < 6; k++) begin
      if (g0 + k < dut_grant_idx.size()) begin
`ifdef CPU_SCHED_FIXED_PRIO_EN
        exp_idx = 0;
`else
        exp_idx = k % N;
`endif
        chk("allvalid_order", dut_grant_idx[g0 + k], exp_idx);
        if (k > 0)
          chk("allvalid_spacing", dut_grant_t[g0 + k] - dut_grant_t[g0 + k - 1], L + 3);
      end
    end
    repeat (L + 3) tick('0, 1);

    // Single directed request from requester 2.
    req_cmd[14 +: 7] = 7'h05;
    req_d1[16 +: 8]  = 8'h03;
    req_d2[16 +: 8]  = 8'h04;
    req_d3[16 +: 8]  = 8'h00;
    waitGrant(4'b0100, 1'b0, 10);
    repeat (L + 3) tick('0, 1'b0);
    chk("single_id", 32'(resp_id), 2);
    chk("single_data", 32'(resp_data), 32'h0007);
    chk("single_flags", 32'({resp_zero, resp_error}), 0);
    chk("single_latency", dut_resp_t[$] - dut_grant_t[$], L + 2);

    // Operand hold: requester 1's inputs change every cycle after its grant.
    waitGrant(4'b0010, 1'b1, 10);
    repeat (L + 3) tick('0, 1'b1);
    chk("hold_id", 32'(resp_id), 1);

    // Error path followed by a normal transaction.
    inject_err = 1'b1;
    waitGrant(4'b0001, 1'b1, 10);
    repeat (L + 3) tick('0, 1'b1);
    chk("err_flag", 32'(resp_error), 1);
    chk("err_id", 32'(resp_id), 0);
    waitGrant(4'b1000, 1'b1, 10);
    repeat (L + 3) tick('0, 1'b1);
    chk("after_err_flag", 32'(resp_error), 0);
    chk("after_err_id", 32'(resp_id), 3);

    // Random request masks that come and go, with occasional CPU errors.
    repeat (300) begin
      inject_err = ($urandom_range(0, 3) == 0);
      tick(N'($urandom), 1'b1);
    end
    inject_err = 1'b0;
    repeat (L + 3) tick('0, 1'b1);

    // Reset three cycles after a grant, then check the first grant after release.
    waitGrant(4'b1010, 1'b1, 20);
    tick(4'b1010, 1'b1);
    tick(4'b1010, 1'b1);
    rst = 1'b0;
    tick(4'b1010, 1'b1);
    tick(4'b1010, 1'b1);
    rst = 1'b1;
    g0 = dut_grant_idx.size();
    waitGrant(4'b1100, 1'b1, 10);
    chk("post_reset_grant_count", 32'(dut_grant_idx.size() - g0), 1);
    if (dut_grant_idx.size() > g0) chk("post_reset_grant_idx", dut_grant_idx[g0], 2);
    repeat (L + 4) tick('0, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
